// File: rtl/fifo_mq_pkg.sv
// Shared widths, allocation encoder and queue-state type for the multi-queue shared FIFO.
package fifo_mq_pkg;

   localparam int unsigned DEPTH_MAX = 256;
   localparam int unsigned PTR_W_MAX = 16;
   localparam int unsigned CNT_W_MAX = 17;

   function automatic int unsigned tag_w(input int unsigned flux);
      return (flux > 1) ? $clog2(flux) : 1;
   endfunction

   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic logic [PTR_W_MAX-1:0] lowest_free(input logic [DEPTH_MAX-1:0] bitmap);
      logic [PTR_W_MAX-1:0] idx;
      idx = '0;
      for (int i = DEPTH_MAX - 1; i >= 0; i--) begin
         if (bitmap[i]) idx = PTR_W_MAX'(i);
      end
      return idx;
   endfunction

   // Fields are sized for the largest supported DEPTH; users slice to their own widths.
   typedef struct packed {
      logic [PTR_W_MAX-1:0] head;
      logic [PTR_W_MAX-1:0] tail;
      logic [CNT_W_MAX-1:0] occ;
   } queue_state_t;

endpackage

// File: rtl/fifo_mq_alloc.sv
// Free-entry allocator: DEPTH-bit free bitmap, lowest-index allocation, bulk release.
module fifo_mq_alloc
   import fifo_mq_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_alloc,
   input  logic [DEPTH-1:0]  i_release,
   output logic [ADDR_W-1:0] o_idx,
   output logic              o_none_free
);

   logic [DEPTH-1:0]     r_free;
   logic [DEPTH-1:0]     w_free_d;
   logic [DEPTH-1:0]     w_alloc_oh;
   logic [PTR_W_MAX-1:0] w_enc;
   logic                 w_enc_unused;

   // Encoder looks only at the registered bitmap, so released entries wait one cycle.
   assign w_enc        = lowest_free(DEPTH_MAX'(r_free));
   assign o_idx        = w_enc[ADDR_W-1:0];
   assign w_enc_unused = ^w_enc[PTR_W_MAX-1:ADDR_W];
   assign o_none_free  = ~|r_free;

   always_comb begin
      w_alloc_oh = '0;
      if (i_alloc) w_alloc_oh[o_idx] = 1'b1;
      w_free_d = (r_free & ~w_alloc_oh) | i_release;
   end

   always_ff @(posedge clk) begin
      if (rst) r_free <= '1;
      else     r_free <= w_free_d;
   end

endmodule

// File: rtl/fifo_mq_shared.sv
// FLUX linked-list queues sharing one DEPTH-entry RAM with per-queue reservations.
// Define FIFO_MQ_STATS_EN to add per-queue level and high-water-mark outputs.
module fifo_mq_shared
   import fifo_mq_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = 8,
   parameter  int unsigned DEPTH      = 8,
   parameter  int unsigned FLUX       = 4,
   parameter  int unsigned RESERVE    = 1,
   localparam int unsigned TAG_W      = tag_w(FLUX),
   localparam int unsigned ADDR_W     = addr_w(DEPTH),
   localparam int unsigned CNT_W      = cnt_w(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       write,
   input  logic [DATA_WIDTH-1:0]      din,
   input  logic [TAG_W-1:0]           din_tag,
   output logic [FLUX-1:0]            full,
   input  logic [FLUX-1:0]            read,
   output logic [FLUX*DATA_WIDTH-1:0] dout,
   output logic [FLUX-1:0]            empty,
   output logic                       err
`ifdef FIFO_MQ_STATS_EN
   ,
   output logic [FLUX*CNT_W-1:0]      level,
   output logic [FLUX*CNT_W-1:0]      hwm
`endif
);

   localparam int unsigned SHARED_CAP = (FLUX * RESERVE > DEPTH) ? 0 : DEPTH - FLUX * RESERVE;
   localparam logic [CNT_W_MAX-1:0] RES_C = CNT_W_MAX'(RESERVE);
   localparam logic [CNT_W_MAX-1:0] CAP_C = CNT_W_MAX'(SHARED_CAP);
   localparam logic [CNT_W_MAX-1:0] ONE_C = CNT_W_MAX'(1);

   if (FLUX * RESERVE > DEPTH) begin : g_bad_reserve
      $error("fifo_mq_shared: FLUX*RESERVE exceeds DEPTH");
   end
   if (DEPTH < 2 || DEPTH > DEPTH_MAX) begin : g_bad_depth
      $error("fifo_mq_shared: DEPTH out of supported range");
   end

   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [ADDR_W-1:0]     r_next [DEPTH];
   queue_state_t          r_q    [FLUX];
   queue_state_t          w_q_d  [FLUX];
   logic                  r_err;

   logic [CNT_W_MAX-1:0]  w_shared_used;
   logic                  w_none_free;
   logic [ADDR_W-1:0]     w_alloc_idx;
   logic [DEPTH-1:0]      w_release;
   logic                  w_tag_ok;
   logic                  w_full_sel;
   logic                  w_wr_ok;
   logic                  w_wr_link;
   logic [ADDR_W-1:0]     w_wr_tail;
   logic [FLUX-1:0]       w_wr_hit;
   logic [FLUX-1:0]       w_rd_ok;
   logic                  w_err_evt;

   fifo_mq_alloc #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_alloc (
      .clk         (clk),
      .rst         (rst),
      .i_alloc     (w_wr_ok),
      .i_release   (w_release),
      .o_idx       (w_alloc_idx),
      .o_none_free (w_none_free)
   );

   always_comb begin
      empty         = '0;
      full          = '0;
      w_shared_used = '0;
      for (int f = 0; f < FLUX; f++) begin
         empty[f] = (r_q[f].occ == '0);
         if (r_q[f].occ > RES_C) w_shared_used = w_shared_used + (r_q[f].occ - RES_C);
      end
      for (int f = 0; f < FLUX; f++) begin
         full[f] = w_none_free || ((r_q[f].occ >= RES_C) && (w_shared_used >= CAP_C));
      end
   end

   // Per-queue decode of the write tag avoids indexing with an out-of-range din_tag.
   always_comb begin
      w_tag_ok   = 1'b0;
      w_full_sel = 1'b0;
      w_wr_tail  = '0;
      w_wr_link  = 1'b0;
      w_wr_hit   = '0;
      for (int f = 0; f < FLUX; f++) begin
         if (din_tag == TAG_W'(f)) begin
            w_tag_ok   = 1'b1;
            w_full_sel = full[f];
            w_wr_tail  = r_q[f].tail[ADDR_W-1:0];
            w_wr_link  = !empty[f];
         end
      end
      w_wr_ok = write && w_tag_ok && !w_full_sel;
      for (int f = 0; f < FLUX; f++) begin
         w_wr_hit[f] = w_wr_ok && (din_tag == TAG_W'(f));
      end
      w_rd_ok   = read & ~empty;
      w_err_evt = (write && (!w_tag_ok || w_full_sel)) || (|(read & empty));
   end

   always_comb begin
      w_q_d     = r_q;
      w_release = '0;
      for (int f = 0; f < FLUX; f++) begin
         if (w_rd_ok[f]) w_release[r_q[f].head[ADDR_W-1:0]] = 1'b1;
         case ({w_wr_hit[f], w_rd_ok[f]})
            2'b10: begin
               if (empty[f]) w_q_d[f].head = PTR_W_MAX'(w_alloc_idx);
               w_q_d[f].tail = PTR_W_MAX'(w_alloc_idx);
               w_q_d[f].occ  = r_q[f].occ + ONE_C;
            end
            2'b01: begin
               w_q_d[f].head = PTR_W_MAX'(r_next[r_q[f].head[ADDR_W-1:0]]);
               w_q_d[f].occ  = r_q[f].occ - ONE_C;
            end
            2'b11: begin
               // A lone entry's next pointer is only being linked now, so bypass it.
               if (r_q[f].occ == ONE_C) w_q_d[f].head = PTR_W_MAX'(w_alloc_idx);
               else w_q_d[f].head = PTR_W_MAX'(r_next[r_q[f].head[ADDR_W-1:0]]);
               w_q_d[f].tail = PTR_W_MAX'(w_alloc_idx);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int f = 0; f < FLUX; f++) r_q[f] <= '0;
         r_err <= 1'b0;
      end else begin
         r_q <= w_q_d;
         if (w_err_evt) r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_wr_ok) begin
         r_data[w_alloc_idx] <= din;
         if (w_wr_link) r_next[w_wr_tail] <= w_alloc_idx;
      end
   end

   assign err = r_err;

   for (genvar f = 0; f < FLUX; f++) begin : g_dout
      assign dout[f*DATA_WIDTH +: DATA_WIDTH] = r_data[r_q[f].head[ADDR_W-1:0]];
   end

`ifdef FIFO_MQ_STATS_EN
   logic [CNT_W-1:0] r_hwm [FLUX];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int f = 0; f < FLUX; f++) r_hwm[f] <= '0;
      end else begin
         for (int f = 0; f < FLUX; f++) begin
            if (w_q_d[f].occ[CNT_W-1:0] > r_hwm[f]) r_hwm[f] <= w_q_d[f].occ[CNT_W-1:0];
         end
      end
   end

   for (genvar f = 0; f < FLUX; f++) begin : g_stats
      assign level[f*CNT_W +: CNT_W] = r_q[f].occ[CNT_W-1:0];
      assign hwm[f*CNT_W +: CNT_W]   = r_hwm[f];
   end
`endif

endmodule
